// File: rtl/async_fifo_write_ctrl.sv
// async_fifo_write_ctrl
// Write-side controller for the asynchronous FIFO. Owns the binary and Gray
// write pointers and synchronizes the read-domain Gray pointer into write_clk.
// From these it derives full, almost_full, the write-side fill level and a
// sticky overflow flag.
//
// Ports:
//   write_clk      in   1     write-domain clock (only clock)
//   write_rst      in   1     synchronous active-high reset
//   write_req      in   1     producer push request
//   read_ptr_gray  in   AW+1  Gray read pointer from the read domain (async)
//   write_en       out  1     memory write enable (combinational)
//   write_addr     out  AW    memory write address (wbin[AW-1:0])
//   write_ptr_gray out  AW+1  registered Gray write pointer to the read domain
//   full           out  1     registered full flag
//   almost_full    out  1     write_level >= ALMOST_FULL_THRESH
//   write_level    out  AW+1  occupancy seen from the write side
//   overflow       out  1     sticky: push attempted while full

module async_fifo_write_ctrl #(
  parameter int unsigned MEMORY_DEPTH       = 8,
  parameter int unsigned ALMOST_FULL_THRESH = 6,
  localparam int unsigned AW                = $clog2(MEMORY_DEPTH),
  localparam int unsigned PW                = AW + 1
) (
  input  logic          write_clk,
  input  logic          write_rst,
  input  logic          write_req,
  input  logic [PW-1:0] read_ptr_gray,
  output logic          write_en,
  output logic [AW-1:0] write_addr,
  output logic [PW-1:0] write_ptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [PW-1:0] write_level,
  output logic          overflow
);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] rq1;
  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_gray;
  logic          full_q;
  logic          overflow_q;

  // Accept a push only when not full; reset also blocks the memory write.
  assign write_en   = write_req & ~full_q & ~write_rst;

  assign wbin_next  = wbin + PW'(write_en);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray value the write pointer has when exactly one lap ahead of the reader.
  assign full_gray  = {~rq2[AW:AW-1], rq2[AW-2:0]};

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_sync[i] = ^(rq2 >> i);
    end
  end

  // Pointer, synchronizer and flag registers.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      wbin       <= '0;
      wgray      <= '0;
      rq1        <= '0;
      rq2        <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      rq1        <= read_ptr_gray;
      rq2        <= rq1;
      full_q     <= (wgray_next == full_gray);
      overflow_q <= overflow_q | (write_req & full_q);
    end
  end

  // Modulo subtraction absorbs pointer wrap; lagging rbin keeps this pessimistic.
  assign write_level    = wbin - rbin_sync;
  assign almost_full    = (write_level >= PW'(ALMOST_FULL_THRESH));

  assign write_addr     = wbin[AW-1:0];
  assign write_ptr_gray = wgray;
  assign full           = full_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/async_fifo_write_ctrl.md
# async_fifo_write_ctrl

Write-side controller for the asynchronous FIFO. It sits directly upstream of `async_fifo_memory` and drives that block's `write_en` and `write_addr` ports. It keeps the binary and Gray write pointers, brings the read-domain Gray read pointer into `write_clk` through a 2-flop synchronizer, and produces `full`, `almost_full`, the fill level and a sticky overflow flag. The registered Gray write pointer goes out for the read-side controller to synchronize.

## Interface
- `MEMORY_DEPTH`, default 8: FIFO depth. Must be a power of 2 and ≥ 4. Must match `async_fifo_memory`.
- `ALMOST_FULL_THRESH`, default 6: `almost_full` asserts when `write_level` ≥ this value. Legal range 1..`MEMORY_DEPTH`.
- Derived `AW = $clog2(MEMORY_DEPTH)`. Pointer width is `AW+1`.

Ports:
- `write_clk`  in  1  write-domain clock. This is the only clock.
- `write_rst`  in  1  reset, synchronous and active-high.
- `write_req`  in  1  producer requests a push this cycle.
- `read_ptr_gray`  in  AW+1  Gray read pointer from the read domain. Asynchronous to `write_clk`.
- `write_en`  out  1  memory write enable. Goes to `async_fifo_memory.write_en`.
- `write_addr`  out  AW  memory write address, equal to `wbin[AW-1:0]`.
- `write_ptr_gray`  out  AW+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  `write_level` ≥ `ALMOST_FULL_THRESH`.
- `write_level`  out  AW+1  occupancy as seen from the write side, range 0..`MEMORY_DEPTH`.
- `overflow`  out  1  sticky flag: a push was attempted while full.

## Operation
- **Accept:** `write_en = write_req & ~full`, combinational. The producer holds its data at `async_fifo_memory.write_data` in the same cycle.
- **Pointer update:** on an accepted push, `wbin <= wbin + 1`. The pointer is modulo 2^(AW+1) and wraps naturally.
- **Gray conversion:** `wgray <= bin2gray(wbin_next)`, where `bin2gray(b) = b ^ (b >> 1)`. `write_ptr_gray = wgray`, driven straight from the register with no combinational logic on the output.
- **Synchronizer:**
  - `rq1 <= read_ptr_gray`, then `rq2 <= rq1`. No logic between the two flops.
  - `rbin_sync = gray2bin(rq2)`, a combinational prefix XOR from the MSB down.
- **Full:** `full <= (bin2gray(wbin_next) == {~rq2[AW:AW-1], rq2[AW-2:0]})`.
- **Level:** `write_level = wbin - rbin_sync`, computed in AW+1 bits. Modulo arithmetic handles wrap, so no extra correction is needed.
- **Pessimism:** the level and flags are deliberately pessimistic, because the synchronized read pointer lags the true one. They never under-report occupancy.
- **Overflow:** `overflow <= overflow | (write_req & full)`. Only `write_rst` clears it.
- **Rejected pushes:** a request while full has no effect on the pointers or the memory.
- **Reset:** at any edge with `write_rst=1`, the following all go to 0:
  - registers `wbin`, `wgray`, `rq1`, `rq2`, `full`, `overflow`;
  - therefore outputs `write_ptr_gray`, `write_addr` and `write_level` read 0;
  - `almost_full` reads 0 (threshold ≥ 1).

  Reset overrides a simultaneous `write_req`, so no write is accepted in the reset cycle.
- **Mid-operation reset:** the write pointer returns to 0 regardless of state. The read side is reset by its own domain, and the system guarantees both sides are reset together.

## Timing
- A push accepted at edge k is visible at edge k as follows:
  - the memory is written;
  - `wbin`/`wgray` advance;
  - `full` reflects the post-push state.
- A push that fills the FIFO raises `full` at the same edge, so the next request is rejected. Back-to-back pushes are accepted at full rate until then.
- A read-pointer change that is stable before edge k:
  - reaches `rq1` at edge k and `rq2` at edge k+1;
  - updates `write_level`/`almost_full` after k+1;
  - deasserts `full` at edge k+2.
- `write_ptr_gray` changes at most 1 bit per `write_clk` edge.
- `full` and `almost_full` may both be high. `write_level` = `MEMORY_DEPTH` exactly when the synchronized state is full.

## Test plan
- **Fill:** with `DEPTH=8`, `read_ptr_gray=0`, hold `write_req` for 9 cycles after reset.
  - 8 writes at addresses 0..7.
  - `full` rises at the 8th edge, with `write_ptr_gray=4'b1100` and `write_level=8`.
  - The 9th cycle has `write_en=0`, and `overflow` = 1 from then on.
- **Almost-full:** 6 pushes give `write_level=6` and `almost_full=1`. After 5 pushes `almost_full` is still 0.
- **Drain release:** from full, set `read_ptr_gray=4'b0001` (rbin 1).
  - `full` stays high 2 edges and drops at the 3rd.
  - `write_level` shows 7 after the 2nd edge.
  - The next push makes `full` = 1 again, with `wbin=9` and `write_addr=1`.
- **Wrap-around:** stream with the read pointer tracking to keep the level ≤ 4 for 40 pushes.
  - `wbin` passes 15→0 and `write_addr` passes 7→0.
  - Each `write_ptr_gray` step has Hamming distance 1.
  - No false `full` at the wrap.
- **Reset mid-operation:** after 5 pushes, assert `write_rst` for 1 cycle together with `write_req`.
  - No write occurs in the reset cycle.
  - All outputs read 0 and `overflow` clears.
  - The next push uses address 0.
- **Simultaneous events:** in the edge where a push makes the FIFO full, the read pointer advances as well.
  - `full` asserts.
  - It deasserts 2 edges later, once the new read pointer reaches `rq2`.
